// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: MSB-first serial word transmitter with Moore-decoded outputs.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [LEN_W-1:0] Len,
    output logic             Ready,
    output logic             Busy,
    output logic             Valid,
    output logic             OUT,
    output logic             Done,
    output logic [1:0]       Estado_Salida
);
    typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, SHIFT = 2'b10, DONE = 2'b11} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_data, r_sreg, w_aligned;
    logic [LEN_W-1:0] r_len, w_len;
    logic [LEN_W:0]   r_cnt, w_cnt_init;
    logic             w_last;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             r_par;
`endif
    assign w_len = (Len == '0 || int'(Len) > WIDTH) ? LEN_W'(WIDTH) : Len;
    // Left-align the word so bit Len-1 lands in the MSB; bits above Len fall off.
    assign w_aligned = r_data << (WIDTH - int'(r_len));
    assign w_last = r_cnt == (LEN_W+1)'(1);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign w_cnt_init = {1'b0, r_len} + (LEN_W+1)'(1);
`else
    assign w_cnt_init = {1'b0, r_len};
`endif
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next        = IDLE;
        Ready         = 1'b0;
        Busy          = 1'b1;
        Valid         = 1'b0;
        OUT           = 1'b0;
        Done          = 1'b0;
        Estado_Salida = r_state;
        case (r_state)
            IDLE: begin
                w_next = Start ? LOAD : IDLE;
                Ready  = 1'b1;
                Busy   = 1'b0;
            end
            LOAD: w_next = SHIFT;
            SHIFT: begin
                w_next = w_last ? DONE : SHIFT;
                Valid  = 1'b1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                OUT    = w_last ? r_par : r_sreg[WIDTH-1];
`else
                OUT    = r_sreg[WIDTH-1];
`endif
            end
            DONE: begin
                w_next = IDLE;
                Done   = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_data <= '0;
            r_len  <= '0;
            r_sreg <= '0;
            r_cnt  <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (Start) begin
                    r_data <= Data;
                    r_len  <= w_len;
                end
                LOAD: begin
                    r_sreg <= w_aligned;
                    r_cnt  <= w_cnt_init;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    r_par  <= ^w_aligned;
`endif
                end
                SHIFT: begin
                    r_sreg <= r_sreg << 1;
                    r_cnt  <= r_cnt - (LEN_W+1)'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: directed self-checking bench for serial_pattern_tx.
module tb_serial_pattern_tx;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    logic       Clk = 1'b0, Reset = 1'b1, Start = 1'b0;
    logic [7:0] Data = '0;
    logic [3:0] Len = '0;
    logic       Ready, Busy, Valid, OUT, Done;
    logic [1:0] Estado_Salida;
    int         n_chk = 0, n_pass = 0;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Data(Data), .Len(Len),
        .Ready(Ready), .Busy(Busy), .Valid(Valid), .OUT(OUT), .Done(Done),
        .Estado_Salida(Estado_Salida)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // bits holds the expected data bits right-aligned, sent MSB-first; par is the hand-computed parity.
    task automatic run(input logic [7:0] d, input logic [3:0] l, input logic [7:0] bits,
                       input int n, input logic par, input bit inject);
        @(negedge Clk);
        Start = 1'b1; Data = d; Len = l;
        @(negedge Clk);
        Start = 1'b0; Data = 8'h00; Len = 4'd1;
        check("load", {Ready, Busy, Valid, OUT, Done, Estado_Salida}, 7'b0100001);
        for (int k = 0; k < n + P; k++) begin
            @(negedge Clk);
            if (inject && k == 1) begin Start = 1'b1; Data = 8'hFF; Len = 4'd8; end
            if (inject && k == 2) Start = 1'b0;
            check("bit", {Valid, OUT, Done, Estado_Salida},
                  {1'b1, (k < n) ? bits[n-1-k] : par, 1'b0, 2'b10});
        end
        @(negedge Clk);
        check("done", {Done, Valid, OUT, Ready, Estado_Salida}, 6'b100011);
        @(negedge Clk);
        check("ready", {Ready, Busy, Done, Estado_Salida}, 5'b10000);
        @(negedge Clk);
        check("idle", {Ready, Done, Valid}, 3'b100);
    endtask

    initial begin
        int gap, t0;
        logic seen;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_state", {Ready, Busy, Valid, OUT, Done, Estado_Salida}, 7'b1000000);
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            check("idle_hold", {Ready, Busy, Valid, OUT, Done, Estado_Salida}, 7'b1000000);
        end
        run(8'h05, 4'd3,  8'b101,      3, 1'b0, 1'b0);
        run(8'hA5, 4'd0,  8'hA5,       8, 1'b0, 1'b0);
        run(8'hA5, 4'd12, 8'hA5,       8, 1'b0, 1'b0);
        run(8'hB6, 4'd5,  8'b10110,    5, 1'b1, 1'b0);
        run(8'hFF, 4'd1,  8'b1,        1, 1'b1, 1'b0);
        run(8'h07, 4'd3,  8'b111,      3, 1'b1, 1'b0);
        run(8'h3C, 4'd8,  8'h3C,       8, 1'b0, 1'b1);
        // Reset during the second SHIFT cycle abandons the word.
        @(negedge Clk);
        Start = 1'b1; Data = 8'hC3; Len = 4'd8;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        check("rst_shift0", {Valid, OUT}, 2'b11);
        @(negedge Clk);
        check("rst_shift1", {Valid, OUT}, 2'b11);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_abort", {Ready, Busy, Valid, OUT, Done, Estado_Salida}, 7'b1000000);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            seen |= Done | Valid;
        end
        check("rst_no_done", seen, 1'b0);
        // Start held high re-triggers at Len+3 (+parity) spacing.
        Start = 1'b1; Data = 8'h02; Len = 4'd2;
        t0 = -1; gap = 0;
        for (int i = 0; i < 40 && gap == 0; i++) begin
            @(negedge Clk);
            if (Done) begin
                if (t0 < 0) t0 = i;
                else gap = i - t0;
            end
        end
        Start = 1'b0;
        check("retrigger_gap", 16'(gap), 16'(5 + P));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Moore-style serial pattern transmitter: accepts a parallel word plus a bit count and shifts it out MSB-first, one bit per clock, on a single serial line. It is the driving end of the serial bit-stream interface consumed by the team's sequence-detector FSMs. Its `OUT` feeds a detector's `IN` directly in loopback benches and in the pattern-generator path. It exposes its 2-bit state code for testbench visibility, matching the detector blocks.

## Interface
Parameters:
- `WIDTH`, default 8: maximum word width in bits (≥2).
- `LEN_W`, default 4: width of `Len`. Must satisfy 2^LEN_W > WIDTH.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Reset`  in  1  reset; synchronous, active-high.
- `Start`  in  1  request to transmit; accepted only when `Ready`=1.
- `Data`  in  WIDTH  word to send; the low `Len` bits are used.
- `Len`  in  LEN_W  bit count, 1..WIDTH. 0 or >WIDTH is clamped to WIDTH.
- `Ready`  out  1  high in IDLE only.
- `Busy`  out  1  high in every state except IDLE.
- `Valid`  out  1  high while `OUT` carries a data (or parity) bit.
- `OUT`  out  1  serial bit; forced 0 when `Valid`=0.
- `Done`  out  1  one-cycle pulse after the last bit.
- `Estado_Salida`  out  2  current state code.

## Operation
- State codes: IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11. The unused code cannot occur; a default branch returns to IDLE.
- Outputs are Moore-decoded from the registered state and shift register, with no combinational path from inputs:
  - `Ready`=IDLE
  - `Busy`=!IDLE
  - `Valid`=SHIFT
  - `Done`=DONE
  - `OUT`=SHIFT ? `sreg[WIDTH-1]` : 0
- IDLE:
  - If `Start`=1, capture `Data` and the clamped `Len` into holding registers and go to LOAD.
  - Otherwise remain in IDLE.
- LOAD:
  - `sreg` <= held data << (WIDTH − Len), so bit Len−1 sits in the MSB.
  - `cnt` <= Len (Len+1 with parity enabled).
  - Go to SHIFT.
- SHIFT:
  - Each cycle: `sreg` <= `sreg` << 1 and `cnt` <= `cnt` − 1.
  - When `cnt`==1, go to DONE.
- DONE: go to IDLE unconditionally.
- `Start` is ignored in LOAD, SHIFT and DONE; it is not queued.
- `Data`/`Len` changes after acceptance do not affect the word in flight.
- `cnt` is LEN_W+1 bits wide so that the Len+1 count cannot wrap.

## Timing
- Reset values (the cycle after `Reset` is sampled high):
  - state=IDLE, `Estado_Salida`=00
  - `Ready`=1, `Busy`=0, `Valid`=0, `OUT`=0, `Done`=0
  - `sreg`=0, `cnt`=0
- `Reset` overrides everything, including mid-SHIFT; a partial word is abandoned with no `Done`.
- With `Start` accepted at edge N:
  - LOAD occupies cycle N+1.
  - First bit is on `OUT` with `Valid`=1 during cycle N+2.
  - Bit k (k=0 is the MSB) appears in cycle N+2+k.
  - `Done`=1 in cycle N+2+Len; IDLE (`Ready`=1) in N+3+Len.
- Minimum `Start`-to-`Start` spacing is Len+3 cycles. `Start` held high continuously re-triggers at exactly that spacing.
- `Valid` is contiguous for Len cycles, with no gaps.

## Configuration
- `SERIAL_PATTERN_TX_PARITY_EN`
- Defined: one extra bit follows the last data bit, inside SHIFT with `Valid`=1.
  - The extra bit is the even parity (XOR) of the Len transmitted bits.
  - `Done` moves to N+3+Len.
  - Minimum spacing becomes Len+4.
- Undefined: no parity bit; timing as above.

## Test plan
- Reset, idle, `Start`=0 for 10 cycles -> `Ready`=1, `Busy`=0, `Valid`=0, `OUT`=0, `Estado_Salida`=00 throughout.
- `Data`=8'h05, `Len`=3, `Start` at N -> `OUT`=1,0,1 in cycles N+2..N+4 and `Done` at N+5. Looped into the detector, the detector output rises after the third bit.
- `Data`=8'hA5, `Len`=0 (clamped to 8) -> `OUT`=1,0,1,0,0,1,0,1 in N+2..N+9; `Done` at N+10; `Ready` at N+11.
- `Start` pulsed again at N+3 with `Data`=8'hFF -> ignored; the original word completes unchanged and no second `Done` occurs.
- `Reset` asserted in the 2nd SHIFT cycle of an 8-bit word -> next cycle IDLE, `Valid`=0, `OUT`=0, `Done` never pulses.
- With the parity macro: `Data`=3'b101, `Len`=3 -> bits 1,0,1,0. `Data`=3'b111 -> bits 1,1,1,1. `Done` at N+6 in both cases.
